// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: double-buffered score word, prescaled
// digit scan, leading-zero blanking, per-digit enable and per-digit blink.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned SEL_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] score,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              dis_seg,
  output logic [NUM_DIGITS-1:0]   dis_sel,
  output logic [SEL_W-1:0]        dis_shu,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      cnt;
  logic [SEL_W-1:0]      idx;
  logic [DATA_W-1:0]     pending;
  logic [DATA_W-1:0]     shown;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_on;

  logic                  tick;
  logic                  wrap;
  logic [SEL_W-1:0]      idx_nxt;
  logic [DATA_W-1:0]     shown_nxt;
  logic                  blink_on_nxt;
  logic [NUM_DIGITS-1:0] lz_vec;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  en_k;
  logic                  bm_k;
  logic                  lz_k;
  logic                  blank;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // Nibble to segment pattern {g,f,e,d,c,b,a}; A..E show a dash, F is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hF:    s = 7'b0000000;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Scan timing and the values that take effect on the coming tick edge.
  always_comb begin
    tick         = (cnt == CNT_LAST);
    wrap         = tick && (idx == IDX_LAST);
    idx_nxt      = (idx == IDX_LAST) ? '0 : idx + SEL_W'(1);
    shown_nxt    = wrap ? (load ? score : pending) : shown;
    blink_on_nxt = (wrap && (blink_cnt == BLK_LAST)) ? ~blink_on : blink_on;
  end

  // Leading-zero mask: bit k set when nibbles k..top of the next shown word are zero.
  always_comb begin
    lz_vec   = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run  = zero_run & (shown_nxt[4*k +: 4] == 4'h0);
      lz_vec[k] = zero_run;
    end
    lz_vec[0] = 1'b0;
  end

  // Select the attributes of the digit about to be scanned and build its drive.
  always_comb begin
    nib  = 4'h0;
    en_k = 1'b0;
    bm_k = 1'b0;
    lz_k = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_nxt == SEL_W'(k)) begin
        nib  = shown_nxt[4*k +: 4];
        en_k = digit_en[k];
        bm_k = blink_mask[k];
        lz_k = lz_vec[k];
      end
    end
    blank   = !en_k || (bm_k && !blink_on_nxt) || (blank_lz && lz_k) || (nib == 4'hF);
    seg_nxt = blank ? 7'b0000000 : seg_decode(nib);
    sel_nxt = blank ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
  end

  // Prescaler, scan index, buffers, blink phase and registered pin drive.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= IDX_LAST;
      pending    <= '0;
      shown      <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      dis_seg    <= '0;
      dis_sel    <= '1;
      dis_shu    <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      frame_done <= wrap;
      if (load) begin
        pending <= score;
      end
      shown    <= shown_nxt;
      blink_on <= blink_on_nxt;
      if (wrap) begin
        blink_cnt <= (blink_cnt == BLK_LAST) ? '0 : blink_cnt + BLK_W'(1);
      end
      if (tick) begin
        idx     <= idx_nxt;
        dis_seg <= seg_nxt;
        dis_sel <= sel_nxt;
        dis_shu <= idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with 4 digits, 4-cycle slots, 2-frame blink.
module tb_seg_scan_mux;

  localparam int ND = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
    logic [1:0] shu;
    logic       fd;
  } exp_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000
  };

  logic        clk_in;
  logic        rst_n;
  logic [15:0] score;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [6:0]  dis_seg;
  logic [3:0]  dis_sel;
  logic [1:0]  dis_shu;
  logic        frame_done;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   slot = 0;
  exp_t sb[$];

  logic [15:0] m_pending;
  logic [15:0] m_shown;
  logic        cfg_lz;
  logic [3:0]  cfg_en;
  logic [3:0]  cfg_bm;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .score     (score),
    .load      (load),
    .blank_lz  (blank_lz),
    .digit_en  (digit_en),
    .blink_mask(blink_mask),
    .dis_seg   (dis_seg),
    .dis_sel   (dis_sel),
    .dis_shu   (dis_shu),
    .frame_done(frame_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected pin drive for digit d of word sh in frame w (frames count from 1).
  function automatic exp_t model(input int d, input logic [15:0] sh, input int w,
                                 input logic lz, input logic [3:0] en, input logic [3:0] bm);
    exp_t       r;
    logic [3:0] n;
    logic       bon;
    logic       upper_zero;
    logic       bl;
    n          = sh[4*d +: 4];
    bon        = ((w / 2) % 2) == 0;
    upper_zero = 1'b1;
    for (int j = d; j < ND; j++) begin
      if (sh[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    bl    = !en[d] || (bm[d] && !bon) || (lz && (d != 0) && upper_zero) || (n == 4'hF);
    r.seg = bl ? 7'b0000000 : SEG_TAB[n];
    r.sel = bl ? 4'hF : ~(4'b0001 << d);
    r.shu = 2'(d);
    r.fd  = (d == 0);
    return r;
  endfunction

  // One scan slot: predict the tick at its end, then drive its four edges.
  task automatic run_slot(input logic [15:0] sc, input int load_edge);
    int d;
    d = slot % ND;
    if (load_edge != 0) m_pending = sc;
    if (d == 0) m_shown = m_pending;
    sb.push_back(model(d, m_shown, slot / ND + 1, cfg_lz, cfg_en, cfg_bm));
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk_in);
      if (e == 1) begin
        score      = sc;
        blank_lz   = cfg_lz;
        digit_en   = cfg_en;
        blink_mask = cfg_bm;
      end
      load = (e == load_edge);
      @(posedge clk_in);
    end
    slot++;
  endtask

  // Monitor: compare each tick edge against the scoreboard, and check pulse width.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      if (!rst_n) begin
        cyc = 0;
      end else begin
        cyc++;
        #1;
        if (cyc % 4 == 0) begin
          if (sb.size() == 0) begin
            chk_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk_eq("seg", 32'(dis_seg), 32'(e.seg));
            chk_eq("sel", 32'(dis_sel), 32'(e.sel));
            chk_eq("shu", 32'(dis_shu), 32'(e.shu));
            chk_eq("frame_done", 32'(frame_done), 32'(e.fd));
          end
        end else if (cyc % 4 == 1) begin
          chk_eq("frame_done_width", 32'(frame_done), 32'd0);
        end else if (cyc == 3) begin
          chk_eq("pre_tick_sel", 32'(dis_sel), 32'hF);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    score      = '0;
    blank_lz   = 1'b0;
    digit_en   = 4'hF;
    blink_mask = 4'h0;
    cfg_lz     = 1'b0;
    cfg_en     = 4'hF;
    cfg_bm     = 4'h0;
    m_pending  = '0;
    m_shown    = '0;

    repeat (3) @(posedge clk_in);
    #1;
    chk_eq("rst_seg", 32'(dis_seg), 32'd0);
    chk_eq("rst_sel", 32'(dis_sel), 32'hF);
    chk_eq("rst_shu", 32'(dis_shu), 32'd0);
    chk_eq("rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk_in);
    #2 rst_n = 1'b1;

    // Basic scan of 1234, then a mid-frame load of 5678.
    run_slot(16'h1234, 1);
    repeat (5) run_slot(16'h1234, 0);
    run_slot(16'h5678, 2);
    repeat (5) run_slot(16'h5678, 0);

    // Leading-zero blanking; second word loaded in the wrap cycle itself.
    cfg_lz = 1'b1;
    run_slot(16'h0070, 1);
    repeat (3) run_slot(16'h0070, 0);
    run_slot(16'h0000, 4);
    repeat (3) run_slot(16'h0000, 0);

    // Blink on digit 0 over six frames.
    cfg_lz = 1'b0;
    cfg_bm = 4'b0001;
    run_slot(16'h1234, 1);
    repeat (23) run_slot(16'h1234, 0);

    // Dash, F blank and digit enable; ends on a wrap so frame_done is high.
    cfg_bm = 4'b0000;
    cfg_en = 4'b1011;
    run_slot(16'hF0A0, 1);
    repeat (8) run_slot(16'hF0A0, 0);

    // Asynchronous reset mid-slot.
    #3 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_seg", 32'(dis_seg), 32'd0);
    chk_eq("async_rst_sel", 32'(dis_sel), 32'hF);
    chk_eq("async_rst_shu", 32'(dis_shu), 32'd0);
    chk_eq("async_rst_fd", 32'(frame_done), 32'd0);
    slot      = 0;
    m_pending = '0;
    m_shown   = '0;
    cfg_en    = 4'hF;
    repeat (2) @(posedge clk_in);
    #2 rst_n = 1'b1;
    repeat (4) run_slot(16'h9999, 0);

    @(negedge clk_in);
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
